// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined 8-op bitwise logic unit with zero flag and saturating result count
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, f;
  logic [2:0]       s1_op;
  logic             en1, en2;
  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;
  always_comb begin
    f = s1_a;
    case (s1_op)
      3'd0:    f = ~(s1_a & s1_b);
      3'd1:    f = s1_a & s1_b;
      3'd2:    f = s1_a | s1_b;
      3'd3:    f = ~(s1_a | s1_b);
      3'd4:    f = s1_a ^ s1_b;
      3'd5:    f = ~(s1_a ^ s1_b);
      3'd6:    f = ~s1_a;
      default: f = s1_a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (en1) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
    end else if (en2) begin
      out_valid <= s1_valid;
      y         <= f;
      zero      <= f == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      op_count <= '0;
    else if (out_valid && out_ready && op_count != '1)
      op_count <= op_count + 1'b1;
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized and directed checks of logic_unit_pipe against an occupancy/queue model
module tb_logic_unit_pipe;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_ready, out_valid, zero;
  logic [7:0] y, op_count;
  logic       s_in_ready, s_out_valid, s_zero;
  logic [7:0] s_y;
  logic [2:0] s_op_count;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero), .op_count(op_count));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .op(op),
    .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y), .zero(s_zero), .op_count(s_op_count));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return ~(x & z);
      3'd1: return x & z;
      3'd2: return x | z;
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Model: ops accepted but not yet delivered, in order; two storage slots in total.
  logic [7:0] q[$];
  logic [7:0] log_y[$];
  logic       log_z[$];
  int         delivered = 0;
  bit         acc_last = 0, chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit e_ir = q.size() < 2 || out_ready;
      automatic bit e_ov = q.size() >= 2 || (q.size() == 1 && !acc_last);
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("sat_in_ready", s_in_ready, e_ir);
      chk("sat_out_valid", s_out_valid, e_ov);
      chk("op_count", op_count, delivered > 255 ? 255 : delivered);
      chk("sat_op_count", s_op_count, delivered > 7 ? 7 : delivered);
      if (e_ov) begin
        chk("y", y, q[0]);
        chk("zero", zero, q[0] == 8'h00);
        chk("sat_y", s_y, q[0]);
        if (out_ready) begin
          log_y.push_back(y);
          log_z.push_back(zero);
        end
      end
      if (rst) begin
        q.delete();
        delivered = 0;
        acc_last = 0;
      end else begin
        if (e_ov && out_ready) begin
          void'(q.pop_front());
          delivered++;
        end
        if (in_valid && e_ir) q.push_back(ref_f(op, a, b));
        acc_last = in_valid && e_ir;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    in_valid = 1'b1; op = o; a = x; b = z;
    step();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_zero"}, zero, 1);
    chk({tag, "_op_count"}, op_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [7:0] tt[8] = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
  logic [7:0] bp[3] = '{8'hFC, 8'h3C, 8'hC0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    step();
    chk_en = 1;
    reset_checks("reset");
    rst = 1'b0;
    // truth table, back to back
    log_y.delete(); log_z.delete();
    for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'hCC);
    in_valid = 1'b0;
    repeat (3) step();
    chk("tt_count", log_y.size(), 8);
    for (int i = 0; i < 8; i++) if (i < log_y.size()) begin
      chk($sformatf("tt_y%0d", i), log_y[i], tt[i]);
      chk($sformatf("tt_z%0d", i), log_z[i], 0);
    end
    chk("tt_op_count", op_count, 8);
    // latency
    send(3'd0, 8'hFF, 8'hFF);
    in_valid = 1'b0;
    chk("lat_ov_edge0", out_valid, 0);
    step();
    chk("lat_ov_edge1", out_valid, 1);
    chk("lat_y", y, 8'h00);
    chk("lat_zero", zero, 1);
    step();
    chk("lat_ov_edge2", out_valid, 0);
    // backpressure
    log_y.delete(); log_z.delete();
    out_ready = 1'b0;
    send(3'd2, 8'hF0, 8'hCC);
    chk("bp_in_ready_1", in_ready, 1);
    send(3'd4, 8'hF0, 8'hCC);
    chk("bp_in_ready_2", in_ready, 0);
    chk("bp_y_hold", y, 8'hFC);
    send(3'd1, 8'hF0, 8'hCC);
    send(3'd1, 8'hF0, 8'hCC);
    chk("bp_in_ready_stall", in_ready, 0);
    chk("bp_y_stall", y, 8'hFC);
    out_ready = 1'b1;
    send(3'd1, 8'hF0, 8'hCC);
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_count", log_y.size(), 3);
    for (int i = 0; i < 3; i++) if (i < log_y.size()) chk($sformatf("bp_y%0d", i), log_y[i], bp[i]);
    // reset mid-flight
    out_ready = 1'b0;
    send(3'd7, 8'hAA, 8'h00);
    send(3'd6, 8'hAA, 8'h00);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_checks("midrst");
    chk("midrst_sat_op_count", s_op_count, 0);
    log_y.delete(); log_z.delete();
    out_ready = 1'b1;
    repeat (3) step();
    chk("midrst_no_emit", log_y.size(), 0);
    // counter saturation
    for (int i = 0; i < 10; i++) send(3'd4, 8'(i), 8'h5A);
    in_valid = 1'b0;
    repeat (3) step();
    chk("sat_reaches_7", s_op_count, 7);
    chk("sat_wide_10", op_count, 10);
    repeat (2) step();
    chk("sat_stays_7", s_op_count, 7);
    // random valid/ready
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rand_drained", q.size(), 0);
    chk("rand_op_count", op_count, delivered > 255 ? 255 : delivered);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
